// File: rtl/npu_ctrl_sequencer.sv
// npu_ctrl_sequencer: generates the manual 8-bit NPU control word for one job
// (clear, input load, MAC, ReLU, PISO latch, byte shift-out) repeated per layer.
//
// Handshakes: an input beat is transferred on every cycle where IN_READY and
// IN_VALID are both high. An output byte is transferred on every SHIFT cycle
// where FULL is low, and WR_EN marks exactly those cycles.
module npu_ctrl_sequencer #(
  parameter int CW = 4,
  parameter int LW = 2
) (
  input  logic          CLKEXT,
  input  logic          RST_GLO,
  input  logic          START,
  input  logic          ABORT,
  input  logic [CW-1:0] CFG_N_IN,
  input  logic [CW-1:0] CFG_MAC_CYC,
  input  logic [CW-1:0] CFG_N_OUT,
  input  logic [LW-1:0] CFG_LAYERS,
  input  logic          IN_VALID,
  input  logic          FULL,
  output logic          IN_READY,
  output logic [7:0]    CTRL,
  output logic          WR_EN,
  output logic          BUSY,
  output logic          DONE,
  output logic [LW-1:0] LAYER,
  output logic [3:0]    DBG_STATE
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_CLR   = 4'd1;
  localparam logic [3:0] S_LOAD  = 4'd2;
  localparam logic [3:0] S_MAC   = 4'd3;
  localparam logic [3:0] S_RELU  = 4'd4;
  localparam logic [3:0] S_LATCH = 4'd5;
  localparam logic [3:0] S_SHIFT = 4'd6;
  localparam logic [3:0] S_NEXT  = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [LW:0]   L_ONE = (LW+1)'(1);

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] n_in_q, n_in_d;
  logic [CW-1:0] mac_q, mac_d;
  logic [CW-1:0] n_out_q, n_out_d;
  logic [LW-1:0] layers_q, layers_d;
  logic [LW-1:0] layer_q, layer_d;

  logic [LW:0] eff_layers;
  logic [LW:0] layer_inc;

  // Layer count of zero behaves as a single layer; compare one bit wider so
  // layer+1 never wraps.
  always_comb begin
    eff_layers = (layers_q == '0) ? L_ONE : {1'b0, layers_q};
    layer_inc  = {1'b0, layer_q} + L_ONE;
  end

  // Next-state and counter logic; ABORT overrides every other transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_in_d   = n_in_q;
    mac_d    = mac_q;
    n_out_d  = n_out_q;
    layers_d = layers_q;
    layer_d  = layer_q;
    case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          n_in_d   = CFG_N_IN;
          mac_d    = CFG_MAC_CYC;
          n_out_d  = CFG_N_OUT;
          layers_d = CFG_LAYERS;
          cnt_d    = '0;
          layer_d  = '0;
          state_d  = S_CLR;
        end
      end
      S_CLR: begin
        cnt_d = '0;
        if (n_in_q != '0)     state_d = S_LOAD;
        else if (mac_q != '0) state_d = S_MAC;
        else                  state_d = S_RELU;
      end
      S_LOAD: begin
        if (IN_VALID) begin
          if (cnt_q == n_in_q - C_ONE) begin
            cnt_d   = '0;
            state_d = (mac_q != '0) ? S_MAC : S_RELU;
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
        end
      end
      S_MAC: begin
        if (cnt_q == mac_q - C_ONE) begin
          cnt_d   = '0;
          state_d = S_RELU;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_RELU: state_d = S_LATCH;
      S_LATCH: begin
        cnt_d   = '0;
        state_d = (n_out_q != '0) ? S_SHIFT : S_NEXT;
      end
      S_SHIFT: begin
        if (!FULL) begin
          if (cnt_q == n_out_q - C_ONE) begin
            cnt_d   = '0;
            state_d = S_NEXT;
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
        end
      end
      S_NEXT: begin
        if (layer_inc < eff_layers) begin
          layer_d = layer_inc[LW-1:0];
          state_d = S_CLR;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        layer_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        layer_d = '0;
        state_d = S_IDLE;
      end
    endcase
    if (ABORT) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      layer_d = '0;
    end
  end

  // State, counter and shadow-config registers.
  always_ff @(posedge CLKEXT or negedge RST_GLO) begin
    if (!RST_GLO) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      n_in_q   <= '0;
      mac_q    <= '0;
      n_out_q  <= '0;
      layers_q <= '0;
      layer_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_in_q   <= n_in_d;
      mac_q    <= mac_d;
      n_out_q  <= n_out_d;
      layers_q <= layers_d;
      layer_q  <= layer_d;
    end
  end

  // Output decode from registered state; only the two handshake strobes see inputs.
  always_comb begin
    IN_READY  = (state_q == S_LOAD);
    CTRL      = 8'h00;
    CTRL[7]   = IN_READY & IN_VALID;
    CTRL[6]   = (state_q == S_CLR);
    CTRL[5]   = (state_q == S_MAC);
    CTRL[4]   = (state_q == S_CLR);
    CTRL[3]   = (state_q == S_RELU);
    CTRL[2]   = (state_q == S_SHIFT) & ~FULL;
    CTRL[1]   = (state_q == S_LATCH);
    CTRL[0]   = (state_q == S_CLR);
    WR_EN     = (state_q == S_SHIFT) & ~FULL;
    BUSY      = (state_q != S_IDLE);
    DONE      = (state_q == S_DONE);
    LAYER     = layer_q;
    DBG_STATE = state_q;
  end

endmodule

// File: tb/tb_npu_ctrl_sequencer.sv
// Directed bench for npu_ctrl_sequencer: cycle-by-cycle expected control words.
module tb_npu_ctrl_sequencer;

  logic       CLKEXT;
  logic       RST_GLO;
  logic       START;
  logic       ABORT;
  logic [3:0] CFG_N_IN;
  logic [3:0] CFG_MAC_CYC;
  logic [3:0] CFG_N_OUT;
  logic [1:0] CFG_LAYERS;
  logic       IN_VALID;
  logic       FULL;
  logic       IN_READY;
  logic [7:0] CTRL;
  logic       WR_EN;
  logic       BUSY;
  logic       DONE;
  logic [1:0] LAYER;
  logic [3:0] DBG_STATE;

  int checks;
  int failures;

  npu_ctrl_sequencer #(.CW(4), .LW(2)) dut (
    .CLKEXT(CLKEXT), .RST_GLO(RST_GLO), .START(START), .ABORT(ABORT),
    .CFG_N_IN(CFG_N_IN), .CFG_MAC_CYC(CFG_MAC_CYC), .CFG_N_OUT(CFG_N_OUT),
    .CFG_LAYERS(CFG_LAYERS), .IN_VALID(IN_VALID), .FULL(FULL),
    .IN_READY(IN_READY), .CTRL(CTRL), .WR_EN(WR_EN), .BUSY(BUSY),
    .DONE(DONE), .LAYER(LAYER), .DBG_STATE(DBG_STATE)
  );

  // Clock / reset
  initial begin
    CLKEXT = 1'b0;
    forever #5 CLKEXT = ~CLKEXT;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge CLKEXT);
    #1;
  endtask

  task automatic set_cfg(input logic [3:0] n_in, input logic [3:0] mac,
                         input logic [3:0] n_out, input logic [1:0] layers);
    CFG_N_IN    = n_in;
    CFG_MAC_CYC = mac;
    CFG_N_OUT   = n_out;
    CFG_LAYERS  = layers;
  endtask

  // Called at cycle start; runs until BUSY drops, bounded, then moves to the next cycle.
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    #2;
    while (BUSY !== 1'b0 && n < 40) begin
      tick();
      #2;
      n++;
    end
    chk(tag, 32'(BUSY), 32'd0);
    tick();
  endtask

  initial begin
    logic [7:0] t1_ctrl [14];
    logic       t1_wr   [14];
    logic       t2_pat  [6];
    logic [7:0] t3_ctrl [9];
    logic       t3_wr   [9];
    int cnt_a;
    int cnt_b;

    checks   = 0;
    failures = 0;
    RST_GLO  = 1'b0;
    START    = 1'b0;
    ABORT    = 1'b0;
    IN_VALID = 1'b0;
    FULL     = 1'b0;
    set_cfg(4'd0, 4'd0, 4'd0, 2'd0);

    // Reset state
    #3;
    chk("rst_ctrl", 32'(CTRL), 32'h00);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_inrdy", 32'(IN_READY), 32'd0);
    chk("rst_wren", 32'(WR_EN), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_layer", 32'(LAYER), 32'd0);
    #5 RST_GLO = 1'b1;
    tick();
    tick();

    // Test 1: single layer N_IN=3 MAC=2 N_OUT=2
    t1_ctrl = '{8'h00, 8'h51, 8'h80, 8'h80, 8'h80, 8'h20, 8'h20,
                8'h08, 8'h02, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00};
    t1_wr   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    set_cfg(4'd3, 4'd2, 4'd2, 2'd1);
    IN_VALID = 1'b1;
    for (int c = 0; c < 14; c++) begin
      START = (c == 0);
      #2;
      chk($sformatf("t1_ctrl_c%0d", c), 32'(CTRL), 32'(t1_ctrl[c]));
      chk($sformatf("t1_wren_c%0d", c), 32'(WR_EN), 32'(t1_wr[c]));
      chk($sformatf("t1_busy_c%0d", c), 32'(BUSY), (c >= 1 && c <= 12) ? 32'd1 : 32'd0);
      chk($sformatf("t1_done_c%0d", c), 32'(DONE), (c == 12) ? 32'd1 : 32'd0);
      tick();
    end
    IN_VALID = 1'b0;

    // Test 2: input stall, config changes mid-job ignored
    t2_pat = '{1, 0, 0, 1, 0, 1};
    cnt_a = 0;
    for (int c = 0; c < 9; c++) begin
      START = (c == 0);
      if (c == 1) CFG_N_IN = 4'd9;
      IN_VALID = (c >= 2 && c <= 7) ? t2_pat[c-2] : (c == 8);
      #2;
      if (c >= 2 && c <= 7) begin
        chk($sformatf("t2_beat_c%0d", c), 32'(CTRL[7]), 32'(t2_pat[c-2]));
        chk($sformatf("t2_inrdy_c%0d", c), 32'(IN_READY), 32'd1);
        if (CTRL[7] === 1'b1) cnt_a++;
      end
      if (c == 8) begin
        chk("t2_mac_start", 32'(CTRL), 32'h20);
        chk("t2_inrdy_off", 32'(IN_READY), 32'd0);
      end
      tick();
    end
    IN_VALID = 1'b0;
    chk("t2_beats", 32'(cnt_a), 32'd3);
    wait_idle("t2_finish");

    // Test 3: output backpressure
    t3_ctrl = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00};
    t3_wr   = '{1, 0, 0, 0, 1, 1, 1, 0, 0};
    set_cfg(4'd1, 4'd1, 4'd4, 2'd1);
    IN_VALID = 1'b1;
    cnt_a = 0;
    for (int c = 0; c < 16; c++) begin
      START = (c == 0);
      FULL  = (c >= 7 && c <= 9);
      #2;
      if (WR_EN === 1'b1) cnt_a++;
      if (c >= 6 && c <= 14) begin
        chk($sformatf("t3_ctrl_c%0d", c), 32'(CTRL), 32'(t3_ctrl[c-6]));
        chk($sformatf("t3_wren_c%0d", c), 32'(WR_EN), 32'(t3_wr[c-6]));
        chk($sformatf("t3_done_c%0d", c), 32'(DONE), (c == 14) ? 32'd1 : 32'd0);
      end
      tick();
    end
    FULL = 1'b0;
    IN_VALID = 1'b0;
    chk("t3_wr_total", 32'(cnt_a), 32'd4);

    // Test 4: three layers, N_IN=0 skips LOAD
    set_cfg(4'd0, 4'd1, 4'd1, 2'd3);
    cnt_a = 0;
    cnt_b = 0;
    for (int c = 0; c < 21; c++) begin
      START = (c == 0);
      #2;
      if (WR_EN === 1'b1) cnt_a++;
      if (DONE === 1'b1) cnt_b++;
      if (c == 1 || c == 7 || c == 13) begin
        chk($sformatf("t4_clr_c%0d", c), 32'(CTRL), 32'h51);
        chk($sformatf("t4_layer_c%0d", c), 32'(LAYER), 32'((c - 1) / 6));
      end
      if (c == 2 || c == 8 || c == 14) begin
        chk($sformatf("t4_mac_c%0d", c), 32'(CTRL), 32'h20);
        chk($sformatf("t4_inrdy_c%0d", c), 32'(IN_READY), 32'd0);
      end
      if (c == 19) chk("t4_done", 32'(DONE), 32'd1);
      if (c == 20) begin
        chk("t4_layer_end", 32'(LAYER), 32'd0);
        chk("t4_busy_end", 32'(BUSY), 32'd0);
      end
      tick();
    end
    chk("t4_wr_total", 32'(cnt_a), 32'd3);
    chk("t4_done_total", 32'(cnt_b), 32'd1);

    // Test 5: ABORT in SHIFT on layer 1
    set_cfg(4'd0, 4'd1, 4'd3, 2'd2);
    cnt_b = 0;
    for (int c = 0; c < 14; c++) begin
      START = (c == 0);
      #2;
      if (DONE === 1'b1) cnt_b++;
      if (c == 13) begin
        chk("t5_shift", 32'(CTRL), 32'h04);
        chk("t5_layer1", 32'(LAYER), 32'd1);
        ABORT = 1'b1;
      end
      tick();
    end
    ABORT = 1'b0;
    #2;
    chk("t5_ab_ctrl", 32'(CTRL), 32'h00);
    chk("t5_ab_busy", 32'(BUSY), 32'd0);
    chk("t5_ab_layer", 32'(LAYER), 32'd0);
    chk("t5_ab_done", 32'(DONE), 32'd0);
    tick();
    #2;
    chk("t5_ab_done2", 32'(DONE), 32'd0);
    chk("t5_done_total", 32'(cnt_b), 32'd0);
    tick();
    // ABORT wins over START in IDLE
    START = 1'b1;
    ABORT = 1'b1;
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    #2;
    chk("t5_abort_prio", 32'(BUSY), 32'd0);
    tick();
    // Fresh job after abort
    set_cfg(4'd3, 4'd2, 4'd2, 2'd1);
    IN_VALID = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0;
    #2;
    chk("t5_restart_clr", 32'(CTRL), 32'h51);
    chk("t5_restart_layer", 32'(LAYER), 32'd0);
    tick();
    wait_idle("t5_restart_finish");
    IN_VALID = 1'b0;

    // Test 6: asynchronous reset in MAC
    set_cfg(4'd0, 4'd5, 4'd1, 2'd1);
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    #2;
    chk("t6_in_mac", 32'(CTRL), 32'h20);
    #1 RST_GLO = 1'b0;
    #1;
    chk("t6_rst_ctrl", 32'(CTRL), 32'h00);
    chk("t6_rst_busy", 32'(BUSY), 32'd0);
    START = 1'b1;
    #1 RST_GLO = 1'b1;
    tick();
    START = 1'b0;
    #2;
    chk("t6_restart_clr", 32'(CTRL), 32'h51);
    chk("t6_restart_busy", 32'(BUSY), 32'd1);
    tick();
    wait_idle("t6_finish");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
